// File: rtl/gray_clk_gen_pkg.sv
// Shared defaults and Gray-code helpers for the gray-clock bus source.
`default_nettype none

package gray_clk_gen_pkg;

  localparam int GRAY_WIDTH    = 19;
  localparam int LO_TAP_BITS   = 7;
  localparam int SINE_BITS_DEF = 8;

  function automatic logic [31:0] bin_to_gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray_to_bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gray_clk_gen_prescaler.sv
// Programmable prescaler: one-cycle adv strobe once every div+1 enabled cycles.
`default_nettype none

module gray_prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  en,
  input  logic                  sync_clr,
  input  logic [PRESCALE_W-1:0] div,
  output logic                  adv
);

  logic [PRESCALE_W-1:0] pc_q;
  logic [PRESCALE_W-1:0] pc_d;

  // >= rather than == so a div lowered below pc advances at once instead of wrapping
  always_comb begin
    pc_d = pc_q;
    adv  = 1'b0;
    if (sync_clr) begin
      pc_d = '0;
    end else if (en) begin
      if (pc_q >= div) begin
        pc_d = '0;
        adv  = 1'b1;
      end else begin
        pc_d = pc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/gray_clk_gen.sv
// Gray-coded clock bus source: binary counter, registered Gray output, slow square wave.
`default_nettype none

module gray_clk_gen
  import gray_clk_gen_pkg::*;
#(
  parameter int WIDTH      = GRAY_WIDTH,
  parameter int PRESCALE_W = 8,
  parameter int SINE_BITS  = SINE_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  en,
  input  logic                  sync_clr,
  input  logic [PRESCALE_W-1:0] div,
  output logic [WIDTH-1:0]      gray_clk,
  output logic                  gray_sine,
  output logic                  tick,
  output logic                  wrap
);

  logic             adv;
  logic [WIDTH-1:0] bin_q, bin_d, bin_inc;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             sine_q, sine_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;

  gray_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .rstb     (rstb),
    .en       (en),
    .sync_clr (sync_clr),
    .div      (div),
    .adv      (adv)
  );

  always_comb begin
    bin_inc = bin_q + 1'b1;
    bin_d   = bin_q;
    gray_d  = gray_q;
    sine_d  = sine_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    if (sync_clr) begin
      bin_d  = '0;
      gray_d = '0;
      sine_d = 1'b0;
    end else if (adv) begin
      bin_d  = bin_inc;
      // Gray of the next count is registered directly, so the bus moves one bit per advance
      gray_d = WIDTH'(bin_to_gray(32'(bin_inc)));
      tick_d = 1'b1;
      wrap_d = &bin_q;
      sine_d = sine_q ^ (&bin_q[SINE_BITS-1:0]);
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      bin_q  <= '0;
      gray_q <= '0;
      sine_q <= 1'b0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      sine_q <= sine_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
    end
  end

  assign gray_clk  = gray_q;
  assign gray_sine = sine_q;
  assign tick      = tick_q;
  assign wrap      = wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_gray_clk_gen.sv
// Directed self-checking bench for gray_clk_gen (12-bit bus keeps the full wrap run short).
`default_nettype none

module tb_gray_clk_gen;
  import gray_clk_gen_pkg::*;

  localparam int W  = 12;
  localparam int PW = 8;
  localparam int SB = 8;

  logic          clk = 1'b0;
  logic          rstb = 1'b0;
  logic          en = 1'b0;
  logic          sync_clr = 1'b0;
  logic [PW-1:0] div = '0;
  logic [W-1:0]  gray_clk;
  logic          gray_sine;
  logic          tick;
  logic          wrap;

  int n_cmp = 0;
  int n_err = 0;

  gray_clk_gen #(
    .WIDTH      (W),
    .PRESCALE_W (PW),
    .SINE_BITS  (SB)
  ) dut (
    .clk       (clk),
    .rstb      (rstb),
    .en        (en),
    .sync_clr  (sync_clr),
    .div       (div),
    .gray_clk  (gray_clk),
    .gray_sine (gray_sine),
    .tick      (tick),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic restart(input logic [PW-1:0] d);
    rstb = 1'b0;
    sync_clr = 1'b0;
    en = 1'b1;
    div = d;
    step();
    rstb = 1'b1;
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    en = 1'b1;
    #2;
    n_cmp++; if (gray_clk !== '0) begin n_err++; $display("FAIL reset_gray: got %h want 0", gray_clk); end
    n_cmp++; if (gray_sine !== 1'b0) begin n_err++; $display("FAIL reset_sine: got %b want 0", gray_sine); end
    n_cmp++; if (tick !== 1'b0) begin n_err++; $display("FAIL reset_tick: got %b want 0", tick); end
    n_cmp++; if (wrap !== 1'b0) begin n_err++; $display("FAIL reset_wrap: got %b want 0", wrap); end
  endtask

  task automatic test_div0_sequence();
    logic [W-1:0] exp_seq [8] = '{12'd1, 12'd3, 12'd2, 12'd6, 12'd7, 12'd5, 12'd4, 12'd12};
    logic [W-1:0] prev;
    restart(8'd0);
    prev = '0;
    for (int k = 0; k < 8; k++) begin
      step();
      n_cmp++; if (gray_clk !== exp_seq[k]) begin n_err++; $display("FAIL div0_gray[%0d]: got %h want %h", k+1, gray_clk, exp_seq[k]); end
      n_cmp++; if (tick !== 1'b1) begin n_err++; $display("FAIL div0_tick[%0d]: got %b want 1", k+1, tick); end
      n_cmp++; if ($countones(gray_clk ^ prev) != 1) begin n_err++; $display("FAIL div0_hamming[%0d]: got %h after %h want one-bit change", k+1, gray_clk, prev); end
      prev = gray_clk;
    end
  endtask

  task automatic test_div3_and_lower();
    logic [W-1:0] exp_g;
    logic         exp_t;
    restart(8'd3);
    exp_g = '0;
    for (int e = 1; e <= 12; e++) begin
      step();
      exp_t = (e % 4 == 0);
      if (e == 4)  exp_g = 12'd1;
      if (e == 8)  exp_g = 12'd3;
      if (e == 12) exp_g = 12'd2;
      n_cmp++; if (gray_clk !== exp_g) begin n_err++; $display("FAIL div3_gray[%0d]: got %h want %h", e, gray_clk, exp_g); end
      n_cmp++; if (tick !== exp_t) begin n_err++; $display("FAIL div3_tick[%0d]: got %b want %b", e, tick, exp_t); end
    end
    step();
    step();
    n_cmp++; if (tick !== 1'b0 || gray_clk !== 12'd2) begin n_err++; $display("FAIL div3_pc2_hold: got gray %h tick %b want 2/0", gray_clk, tick); end
    div = 8'd0;
    step();
    n_cmp++; if (gray_clk !== 12'd6 || tick !== 1'b1) begin n_err++; $display("FAIL div_lowered_adv: got gray %h tick %b want 6/1", gray_clk, tick); end
  endtask

  task automatic test_freeze();
    div = 8'd2;
    step();
    n_cmp++; if (gray_clk !== 12'd6 || tick !== 1'b0) begin n_err++; $display("FAIL freeze_pre: got gray %h tick %b want 6/0", gray_clk, tick); end
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      n_cmp++; if (gray_clk !== 12'd6 || tick !== 1'b0 || gray_sine !== 1'b0) begin
        n_err++; $display("FAIL freeze_hold[%0d]: got gray %h tick %b sine %b want 6/0/0", k, gray_clk, tick, gray_sine);
      end
    end
    en = 1'b1;
    step();
    n_cmp++; if (gray_clk !== 12'd6 || tick !== 1'b0) begin n_err++; $display("FAIL freeze_resume1: got gray %h tick %b want 6/0", gray_clk, tick); end
    step();
    n_cmp++; if (gray_clk !== 12'd7 || tick !== 1'b1) begin n_err++; $display("FAIL freeze_resume2: got gray %h tick %b want 7/1", gray_clk, tick); end
  endtask

  task automatic test_sync_clr();
    restart(8'd0);
    for (int k = 0; k < 300; k++) step();
    n_cmp++; if (gray_sine !== 1'b1) begin n_err++; $display("FAIL clr_pre_sine: got %b want 1", gray_sine); end
    sync_clr = 1'b1;
    step();
    n_cmp++; if (gray_clk !== '0 || gray_sine !== 1'b0 || tick !== 1'b0 || wrap !== 1'b0) begin
      n_err++; $display("FAIL clr_state: got gray %h sine %b tick %b wrap %b want all 0", gray_clk, gray_sine, tick, wrap);
    end
    sync_clr = 1'b0;
    div = 8'd2;
    step();
    step();
    n_cmp++; if (gray_clk !== '0 || tick !== 1'b0) begin n_err++; $display("FAIL clr_wait: got gray %h tick %b want 0/0", gray_clk, tick); end
    step();
    n_cmp++; if (gray_clk !== 12'd1 || tick !== 1'b1) begin n_err++; $display("FAIL clr_first_adv: got gray %h tick %b want 1/1", gray_clk, tick); end
  endtask

  task automatic test_wrap();
    logic [W-1:0] prev;
    logic [W-1:0] pre_wrap;
    logic [W-1:0] at_wrap;
    logic         prev_sine;
    int wrap_cnt, wrap_k, toggles, first_tog, ham_err, bin_err, tick_cnt;
    logic [31:0] b;
    restart(8'd0);
    prev = '0; prev_sine = 1'b0; pre_wrap = '1; at_wrap = '1;
    wrap_cnt = 0; wrap_k = 0; toggles = 0; first_tog = 0; ham_err = 0; bin_err = 0; tick_cnt = 0;
    for (int k = 1; k <= 4096; k++) begin
      step();
      if (wrap) begin wrap_cnt++; wrap_k = k; pre_wrap = prev; at_wrap = gray_clk; end
      if (gray_sine !== prev_sine) begin toggles++; if (first_tog == 0) first_tog = k; end
      if ($countones(gray_clk ^ prev) != 1) ham_err++;
      b = gray_to_bin(32'(gray_clk));
      if (b != 32'(k % 4096)) bin_err++;
      if (tick) tick_cnt++;
      prev = gray_clk;
      prev_sine = gray_sine;
    end
    n_cmp++; if (wrap_cnt != 1) begin n_err++; $display("FAIL wrap_count: got %0d want 1", wrap_cnt); end
    n_cmp++; if (wrap_k != 4096) begin n_err++; $display("FAIL wrap_edge: got %0d want 4096", wrap_k); end
    n_cmp++; if (pre_wrap !== 12'h800 || at_wrap !== 12'h000) begin n_err++; $display("FAIL wrap_codes: got %h->%h want 800->000", pre_wrap, at_wrap); end
    n_cmp++; if (toggles != 16) begin n_err++; $display("FAIL sine_toggles: got %0d want 16", toggles); end
    n_cmp++; if (first_tog != 256) begin n_err++; $display("FAIL sine_first: got %0d want 256", first_tog); end
    n_cmp++; if (ham_err != 0) begin n_err++; $display("FAIL wrap_hamming: got %0d bad steps want 0", ham_err); end
    n_cmp++; if (bin_err != 0) begin n_err++; $display("FAIL wrap_decode: got %0d bad codes want 0", bin_err); end
    n_cmp++; if (tick_cnt != 4096) begin n_err++; $display("FAIL wrap_ticks: got %0d want 4096", tick_cnt); end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 5; k++) step();
    n_cmp++; if (gray_clk !== 12'd7) begin n_err++; $display("FAIL arst_pre: got %h want 7", gray_clk); end
    @(posedge clk);
    #3;
    rstb = 1'b0;
    #1;
    n_cmp++; if (gray_clk !== '0 || tick !== 1'b0 || gray_sine !== 1'b0) begin
      n_err++; $display("FAIL arst_immediate: got gray %h tick %b sine %b want 0/0/0", gray_clk, tick, gray_sine);
    end
    step();
    rstb = 1'b1;
    step();
    n_cmp++; if (gray_clk !== 12'd1) begin n_err++; $display("FAIL arst_restart1: got %h want 1", gray_clk); end
    step();
    n_cmp++; if (gray_clk[7:1] !== 7'd1) begin n_err++; $display("FAIL arst_lo_tap: got %h want 01", gray_clk[7:1]); end
  endtask

  initial begin
    test_reset();
    test_div0_sequence();
    test_div3_and_lower();
    test_freeze();
    test_sync_clr();
    test_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gray_clk_gen.md
Name: gray_clk_gen

Overview:
- Source end of the gray-clock bus: produces the multi-bit Gray-coded clock bus and the slow gray_sine square wave consumed by the per-core LO banks.
- A programmable prescaler sets the master advance rate (pitch); a binary counter is converted to Gray and registered, so only one bus bit toggles per advance.
- Sits once per unison, upstream of all LO instances; each core taps a 7-bit window of gray_clk.

Parameters:
- WIDTH, 19, number of gray_clk bits (binary counter width)
- PRESCALE_W, 8, width of the div input and prescaler counter
- SINE_BITS, 8, gray_sine toggles on each wrap of the low SINE_BITS bits of the binary counter

Ports:
- clk  input  1  master clock
- rstb  input  1  asynchronous active-low reset
- en  input  1  advance enable; low freezes all state
- sync_clr  input  1  synchronous clear of all state; priority over en
- div  input  PRESCALE_W  counter advances once every div+1 enabled clk cycles
- gray_clk  output  WIDTH  registered Gray code of the binary counter
- gray_sine  output  1  registered square wave, period 2^(SINE_BITS+1) advances
- tick  output  1  one-cycle pulse, high in the cycle gray_clk shows a new value
- wrap  output  1  one-cycle pulse, high in the cycle gray_clk returns to 0 by counting

Behaviour:
- Reset (rstb low, async): prescaler count pc=0, bin=0, gray_clk=0, gray_sine=0, tick=0, wrap=0.
- Priority at each rising clk edge: sync_clr, then en, then hold.
- sync_clr=1: pc, bin, gray_clk, gray_sine all set to 0. tick=0, wrap=0. en is ignored.
- en=0 and sync_clr=0: all state holds; tick=0 and wrap=0 on the next edge.
- en=1, prescaler:
  - if pc >= div: pc<=0 and an advance occurs.
  - else: pc<=pc+1, no advance.
  - The >= compare means lowering div below the current pc forces an advance on the next edge, never a long wrap.
  - A div change takes effect on the next edge with no restart.
- Advance:
  - bin<=bin+1, modulo 2^WIDTH.
  - gray_clk<=(bin+1)^((bin+1)>>1).
  - tick<=1.
  - wrap<=1 only when bin was all-ones.
  - gray_sine toggles when bin[SINE_BITS-1:0] is all-ones (low field wraps to 0).
- Non-advance edges: tick<=0, wrap<=0.
- Latency: with en held high from reset release, the first gray_clk change occurs on edge div+1. Thereafter gray_clk changes every div+1 edges. div=0 advances every edge.
- Glitch-free: gray_clk, gray_sine, tick and wrap are all direct flop outputs; exactly one gray_clk bit changes per advance, including at the all-ones to 0 wrap.
- Reset mid-operation: async; outputs go to 0 immediately, without waiting for clk. Counting resumes from 0 once rstb is high and en=1.
- Simultaneous sync_clr and pc>=div: clear wins; no tick.

Decomposition:
- Shared package:
  - GRAY_WIDTH=19, LO_TAP_BITS=7, SINE_BITS=8 defaults.
  - bin_to_gray function; gray_to_bin function for bench checking.
- One sub-module, gray_prescaler:
  - Inputs: clk, rstb, en, sync_clr, div.
  - Output: adv strobe.
  - Top holds the binary counter, Gray conversion and output registers.

Test Plan:
- Reset with en=1, div=0: gray_clk sequence from edge 1 is 1,3,2,6,7,5,4,12…; tick high every cycle; each consecutive pair differs in exactly one bit (Hamming distance 1).
- div=3, en=1: gray_clk changes only on edges 4,8,12; tick is high exactly in those cycles. Set div=0 while pc=2: advance occurs on the next edge.
- WIDTH=19, div=0, run 2^19 advances: wrap pulses once as gray_clk goes 0x40000 to 0 (one-bit change). gray_sine toggles every 256 advances, so the first toggle is at advance 256 and there are 2048 toggles in total.
- en low for 10 cycles mid-count: gray_clk, gray_sine and pc frozen, tick=0. On re-enable, counting resumes exactly where it left off, with no skipped or repeated code.
- Assert sync_clr together with en on an advance edge: next value is gray_clk=0, gray_sine=0, tick=0. The first advance after release occurs div+1 edges later.
- Drop rstb between clk edges: outputs go to 0 before the next edge. gray_clk[7:1] feeding an LO instance then restarts from 0.
